// File: rtl/monostable_pkg.sv
// Shared definitions for the monostable pulse-stretcher array: trigger-mode
// encoding and default sizing constants.
package monostable_pkg;

  localparam int unsigned CH_DEF   = 4;
  localparam int unsigned PW_W_DEF = 8;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

endpackage

// File: rtl/mono_chan.sv
// One monostable channel: optional 2-flop synchroniser (MONO_SYNC_EN), input
// history, edge detect, registered trigger and pulse-length down-counter.
module mono_chan
  import monostable_pkg::*;
#(
  parameter int unsigned PW_W = PW_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sig,
  input  logic [1:0]      i_edge_mode,
  input  logic            i_retrig,
  input  logic [PW_W-1:0] i_pw,
  output logic            o_out,
  output logic            o_out_next
);

  logic            w_s;
  logic            w_edge;
  logic [PW_W-1:0] w_pw_eff;
  logic [PW_W-1:0] w_cnt_next;
  edge_mode_t      w_mode;

  logic            r_sig_d;
  logic            r_trig;
  logic [PW_W-1:0] r_cnt;
  logic            r_out;

`ifdef MONO_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_sig};
  end

  assign w_s = r_sync[1];
`else
  assign w_s = i_sig;
`endif

  assign w_mode   = edge_mode_t'(i_edge_mode);
  assign w_pw_eff = (i_pw == '0) ? PW_W'(1) : i_pw;

  always_comb begin
    w_edge = 1'b0;
    case (w_mode)
      EDGE_RISE: w_edge = w_s & ~r_sig_d;
      EDGE_FALL: w_edge = ~w_s & r_sig_d;
      EDGE_BOTH: w_edge = w_s ^ r_sig_d;
      default:   w_edge = 1'b0;
    endcase
  end

  // The detected edge is registered once so out rises one edge after detection;
  // out then mirrors counter != 0 exactly, so "counter = 1" is the last high cycle.
  always_comb begin
    w_cnt_next = r_cnt;
    if (r_trig && (i_retrig || (r_cnt == '0)))
      w_cnt_next = w_pw_eff;
    else if (r_cnt != '0)
      w_cnt_next = r_cnt - PW_W'(1);
  end

  assign o_out_next = (w_cnt_next != '0);
  assign o_out      = r_out;

  always_ff @(posedge i_clk) begin
    r_sig_d <= w_s;
    if (!i_rst) begin
      r_trig <= 1'b0;
      r_cnt  <= '0;
      r_out  <= 1'b0;
    end else begin
      r_trig <= w_edge;
      r_cnt  <= w_cnt_next;
      r_out  <= o_out_next;
    end
  end

endmodule

// File: rtl/monostable_array.sv
// Array of CH independent retriggerable/non-retriggerable monostables with a
// registered busy flag. Define MONO_SYNC_EN to synchronise each sig bit.
module monostable_array
  import monostable_pkg::*;
#(
  parameter int unsigned CH   = CH_DEF,
  parameter int unsigned PW_W = PW_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   sig,
  input  logic [1:0]      edge_mode,
  input  logic            retrig,
  input  logic [PW_W-1:0] pw,
  output logic [CH-1:0]   out,
  output logic            busy
);

  logic [CH-1:0] w_out_next;
  logic          r_busy;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    mono_chan #(
      .PW_W(PW_W)
    ) u_chan (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_sig      (sig[g]),
      .i_edge_mode(edge_mode),
      .i_retrig   (retrig),
      .i_pw       (pw),
      .o_out      (out[g]),
      .o_out_next (w_out_next[g])
    );
  end

  // Built from next-state values so busy switches on the same edge as out.
  always_ff @(posedge clk) begin
    if (!rst) r_busy <= 1'b0;
    else      r_busy <= |w_out_next;
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_monostable_array.sv
// Randomized and directed bench for monostable_array; reference model tracks
// each channel as a "high through edge N" timestamp.
module tb_monostable_array;

  localparam int unsigned CH   = 4;
  localparam int unsigned PW_W = 8;
`ifdef MONO_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CH-1:0]   sig = '0;
  logic [1:0]      edge_mode = 2'b00;
  logic            retrig = 1'b0;
  logic [PW_W-1:0] pw = '0;
  logic [CH-1:0]   out;
  logic            busy;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  monostable_array #(.CH(CH), .PW_W(PW_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .edge_mode(edge_mode),
    .retrig   (retrig),
    .pw       (pw),
    .out      (out),
    .busy     (busy)
  );

  // Model: edge count, last edge index each channel is high through,
  // trigger pending acceptance, input history and synchroniser stages.
  int cyc = 0;
  int hi_until[CH];
  bit prev[CH];
  bit pend[CH];
  bit s1[CH];
  bit s2[CH];

  int hi_cnt, rise_cnt, oth_cnt, tk, first_hi;
  bit last_o;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit det(input bit s, input bit p, input logic [1:0] m);
    case (m)
      2'b00:   return s & !p;
      2'b01:   return !s & p;
      2'b10:   return s ^ p;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CH-1:0] m_out();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (cyc <= hi_until[i]);
    return r;
  endfunction

  task automatic model_step();
    cyc++;
    for (int i = 0; i < CH; i++) begin
      bit samp;
`ifdef MONO_SYNC_EN
      samp = s2[i];
`else
      samp = sig[i];
`endif
      if (!rst) begin
        hi_until[i] = -1;
        pend[i]     = 1'b0;
        prev[i]     = samp;
        s1[i]       = 1'b0;
        s2[i]       = 1'b0;
      end else begin
        if (pend[i] && (retrig || hi_until[i] < cyc - 1))
          hi_until[i] = cyc + ((pw == 0) ? 1 : int'(pw)) - 1;
        pend[i] = det(samp, prev[i], edge_mode);
        prev[i] = samp;
        s2[i]   = s1[i];
        s1[i]   = sig[i];
      end
    end
  endtask

  task automatic clr();
    hi_cnt = 0; rise_cnt = 0; oth_cnt = 0; tk = 0; first_hi = -1; last_o = 1'b0;
  endtask

  task automatic tick(input int ch);
    logic [CH-1:0] mask;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("out", 32'(out), 32'(m_out()));
    check("busy", 32'(busy), 32'(|m_out()));
    tk++;
    mask = '0;
    mask[ch] = 1'b1;
    if (out[ch]) hi_cnt++;
    if (out[ch] && first_hi < 0) first_hi = tk;
    if (out[ch] && !last_o) rise_cnt++;
    last_o = out[ch];
    oth_cnt += $countones(out & ~mask);
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      hi_until[i] = -1; prev[i] = 1'b0; pend[i] = 1'b0; s1[i] = 1'b0; s2[i] = 1'b0;
    end
    clr();

    repeat (3) tick(0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (3) tick(0);

    // single rising-edge pulse, pw=5
    edge_mode = 2'b00; pw = 5; retrig = 1'b0;
    clr(); sig[0] = 1'b1;
    repeat (12) tick(0);
    check("w028_width", hi_cnt, 5);
    check("w028_lat", first_hi, LAT);

    // pw=3 pulse width and latency
    sig[0] = 1'b0; repeat (6) tick(0);
    pw = 3; clr(); sig[0] = 1'b1;
    repeat (10) tick(0);
    check("w033_width", hi_cnt, 3);
    check("w033_lat", first_hi, LAT);

    // retriggerable extension
    sig[0] = 1'b0; repeat (8) tick(0);
    retrig = 1'b1; pw = 4; clr();
    sig[0] = 1'b1; tick(0);
    sig[0] = 1'b0; tick(0);
    sig[0] = 1'b1; repeat (12) tick(0);
    check("w029_width", hi_cnt, 6);
    check("w029_rises", rise_cnt, 1);

    // non-retriggerable, edge lands on counter=1
    sig[0] = 1'b0; repeat (8) tick(0);
    retrig = 1'b0; pw = 4; clr();
    sig[0] = 1'b1; tick(0);
    sig[0] = 1'b0; tick(0); tick(0); tick(0);
    sig[0] = 1'b1; repeat (10) tick(0);
    check("w030_width", hi_cnt, 4);
    check("w030_rises", rise_cnt, 1);

    // both edges, pw=0 -> 1-cycle pulse per toggle
    sig[0] = 1'b0; repeat (8) tick(0);
    edge_mode = 2'b10; pw = 0; clr();
    for (int t = 0; t < 8; t++) begin
      sig[2] = ~sig[2];
      repeat (3) tick(2);
    end
    repeat (4) tick(2);
    check("w031_width", hi_cnt, 8);
    check("w031_rises", rise_cnt, 8);
    check("w031_others", oth_cnt, 0);

    // level held through reset release, then reset mid-pulse
    edge_mode = 2'b00;
    rst = 1'b0; sig[1] = 1'b1; repeat (3) tick(1);
    rst = 1'b1; clr(); repeat (10) tick(1);
`ifndef MONO_SYNC_EN
    check("w032_hold", hi_cnt, 0);
`endif
    pw = 10; sig[0] = 1'b1; repeat (LAT + 2) tick(0);
    check("w032_pre", 32'(out[0]), 32'd1);
    rst = 1'b0; tick(0);
    check("w032_rst", 32'(out), 32'd0);
    rst = 1'b1; repeat (15) tick(0);

    // maximum pulse length
    sig = '0; repeat (8) tick(3);
    pw = 8'd255; retrig = 1'b0; clr();
    sig[3] = 1'b1; repeat (262) tick(3);
    check("max_width", hi_cnt, 255);

    // random traffic, including mid-pulse pw/mode/retrig changes and resets
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(3) == 0) sig[i] = ~sig[i];
      if ($urandom_range(15) == 0) edge_mode = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) retrig = 1'($urandom_range(1));
      if ($urandom_range(7) == 0)  pw = PW_W'($urandom_range(6));
      rst = ($urandom_range(63) != 0);
      tick(0);
    end
    rst = 1'b1;
    repeat (10) tick(0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/monostable_array.md
MONOSTABLE_ARRAY -- requirements
Module: monostable_array

Interface
REQ-001 Parameter CH, default 4: number of independent trigger channels, 1..32.
REQ-002 Parameter PW_W, default 8: width of the pulse-width input; maximum pulse length 2^PW_W-1 cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 sig  input  CH  per-channel trigger inputs, asynchronous to nothing (clk-domain unless MONO_SYNC_EN).
REQ-006 edge_mode  input  2  global trigger mode: 00 rising, 01 falling, 10 both edges, 11 disabled.
REQ-007 retrig  input  1  1 = retriggerable, 0 = non-retriggerable.
REQ-008 pw  input  PW_W  output pulse length in cycles; pw=0 is treated as 1.
REQ-009 out  output  CH  per-channel stretched pulse, registered.
REQ-010 busy  output  1  OR of all out bits, registered.

Function
REQ-011 Each channel SHALL hold a one-cycle history sig_d of its (possibly synchronised) input and detect an edge when the sampled input differs from sig_d in the direction selected by edge_mode.
REQ-012 An edge detected at rising edge k SHALL drive out[i] high from edge k+1 for exactly max(pw,1) consecutive cycles, then low.
REQ-013 Each channel SHALL use a down-counter of PW_W bits loaded with max(pw,1) on accepted trigger; out[i] is high while counter is non-zero.
REQ-014 With retrig=1, an edge while out[i] is high SHALL reload the counter, so out[i] stays high max(pw,1) cycles after the latest edge, with no low gap.
REQ-015 With retrig=0, edges while out[i] is high SHALL be ignored; an edge in the final active cycle (counter=1) SHALL be ignored and out[i] SHALL fall for at least one cycle.
REQ-016 pw SHALL be sampled only at trigger acceptance; changes mid-pulse SHALL not alter the running pulse.
REQ-017 edge_mode=11 SHALL block new triggers; running pulses SHALL complete normally.
REQ-018 edge_mode or retrig changes SHALL take effect at the next rising edge; sig_d SHALL keep updating in all modes.
REQ-019 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each trigger.
REQ-020 busy SHALL equal the OR of the next-cycle out values, asserting/deasserting in the same cycle as out.

Reset
REQ-021 While rst=0 at a clock edge: out=0, busy=0, all counters=0, synchroniser flops=0.
REQ-022 While rst=0, sig_d SHALL load the current sampled input, so a level held high across reset release SHALL NOT trigger.
REQ-023 Reset asserted mid-pulse SHALL terminate the pulse at the next clock edge.

Configuration
REQ-024 Macro MONO_SYNC_EN defined: each sig bit SHALL pass a 2-flop synchroniser before edge detection, adding 2 cycles of latency (out rises at edge k+3 for a sig change before edge k).
REQ-025 MONO_SYNC_EN undefined: sig SHALL feed edge detection directly, latency per REQ-012.

Structure
REQ-026 Package monostable_pkg SHALL hold the edge_mode encoding (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF) as a typedef and the default parameter constants.
REQ-027 Per-channel logic (history, edge detect, counter) SHALL be sub-module mono_chan, instantiated CH times by a generate loop; busy logic at top.

Verification
REQ-028 rising mode, pw=5, retrig=0, sig[0] 0->1 -> out[0] high exactly 5 cycles starting the cycle after the edge; busy identical.
REQ-029 retrig=1, pw=4, second rising edge 2 cycles into pulse -> out[0] continuous high for 6 cycles total.
REQ-030 retrig=0, pw=4, second edge at counter=1 -> out[0] high 4 cycles, low >=1 cycle, no retrigger.
REQ-031 both-edge mode, pw=0, sig[2] toggles every 3 cycles -> one-cycle out[2] pulse per toggle; other channels remain 0.
REQ-032 sig[1] held high through reset release, rst pulsed low mid-pulse -> no pulse after release; active pulse cleared on next edge.
REQ-033 With MONO_SYNC_EN, pw=3, rising edge -> out[0] rises 2 cycles later than without macro, width 3.
